rom_4kb_arbiter: RTL and testbench
==================================

Name: rom_4kb_arbiter

Overview:
- Two-requester arbiter and sequencer for the 4 KB byte-wide memory (12-bit address, 8-bit data, single write_enable, synchronous read).
- Accepts one request at a time over a valid/ready handshake and drives the memory control pins for that request.
- Returns read data or a write acknowledge on a one-cycle response pulse to the requester that issued the request.
- Sits between the memory and two masters, e.g. a loader and a CPU fetch port.

Parameters:
- ADDR_W, 12, memory address width (4096 locations)
- DATA_W, 8, memory data width
- RD_LAT, 1, memory read latency in clocks from the address-driven cycle; legal range 1..4
- PROT_TOP, 12'h0FF, highest write-protected address; used only when MEM_WR_PROTECT_EN is defined

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_we / req1_we  in  1  1=write, 0=read
- req0_addr / req1_addr  in  ADDR_W  access address
- req0_wdata / req1_wdata  in  DATA_W  write data
- rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data, held until next read response to that port
- rsp0_err / rsp1_err  out  1  protection-violation flag, qualified by rspN_valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  requester currently owning the memory; valid while busy

Behaviour:
- Reset values (async, immediate on rst_n low): state=IDLE; mem_we, mem_addr, mem_wdata, all rsp*, busy, grant_id = 0; round-robin pointer favours req0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational and asserts only in IDLE, for the selected requester only. Never both readys high.
  - Selection: if exactly one valid, that requester is selected. If both valid, the requester not granted last is selected.
  - On the accept edge: register we/addr/wdata into mem_*, record grant_id, flip the RR pointer, go to ACCESS.
- ACCESS (1 cycle): mem_addr/mem_wdata driven; mem_we = latched we.
  - Write -> RESP.
  - Read -> WAIT.
- WAIT: counts RD_LAT cycles. mem_we = 0, mem_addr held. Capture mem_rdata into rsp<grant>_rdata on the final WAIT edge, then -> RESP.
- RESP (1 cycle): rsp<grant>_valid = 1; the other port's rsp_valid stays 0; then -> IDLE.
- Latency from accept edge to rsp_valid high: write 2 cycles; read 2+RD_LAT cycles. Throughput: one access per 3 (write) or 3+RD_LAT (read) cycles.
- mem_we is high only in ACCESS of a permitted write: exactly one cycle per write.
- mem_addr holds its last value in IDLE. No glitching back to 0.
- Write responses leave rspN_rdata unchanged.
- Requester rules:
  - Must hold addr/we/wdata stable while valid and not ready.
  - Dropping valid before accept is legal: no access, no response.
  - A request arriving while busy waits; ready stays low.
- Reset mid-operation: the in-flight access is abandoned with no response, mem_we drops immediately, and the FSM restarts in IDLE with the pointer favouring req0.
- Address arithmetic: none. The full ADDR_W range is legal, including 12'hFFF.

Optional Feature:
- MEM_WR_PROTECT_EN defined:
  - A write with addr <= PROT_TOP is accepted normally but mem_we stays 0 in ACCESS.
  - The RESP pulse carries rspN_err = 1.
  - Reads are never protected.
- MEM_WR_PROTECT_EN undefined: rsp0_err/rsp1_err are tied 0 and every write reaches memory. Ports are present in both builds.

Test Plan:
- Reset check: hold rst_n=0 with req0_valid=1 -> all outputs 0, req0_ready=0. Release -> req0_ready=1 in the same IDLE cycle.
- Single write/read on req0: write 8'hA5 to 12'h000, then read 12'h000 with RD_LAT=1 -> mem_we high exactly 1 cycle; rsp0_valid 2 cycles after write accept; rsp0_rdata=8'hA5 exactly 3 cycles after read accept.
- Contention: both requesters continuously valid, req0 writing 12'h001=8'h5A and req1 reading 12'h002 -> grants alternate 0,1,0,1. rsp1_valid never coincides with rsp0_valid. Each response goes only to its owner.
- Boundary address: req1 writes 12'hFFF=8'hFF then reads it back -> rsp1_rdata=8'hFF. Also, req0 deasserts valid before it is ever granted -> no access and no rsp0_valid.
- Reset mid-read: assert rst_n low during WAIT -> no rsp pulse, busy=0 immediately. A subsequent read completes normally.
- With MEM_WR_PROTECT_EN: write 8'h00 to 12'h0FF -> mem_we stays 0, rsp0_err=1, and a later read returns the old value. Write to 12'h100 -> mem_we pulses, rsp0_err=0.

Source files
------------

// File: rtl/rom_4kb_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a 4 KB byte-wide synchronous memory.
// Optional write protection of the low region is enabled by defining MEM_WR_PROTECT_EN.
module rom_4kb_arbiter #(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       RD_LAT   = 1,
    parameter logic [ADDR_W-1:0] PROT_TOP = ADDR_W'(12'h0FF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              favour, favour_nx;
    logic              lat_we, lat_we_nx;
    logic              lat_err, lat_err_nx;
    logic              mem_we_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic              busy_nx, grant_nx;
    logic              rsp0_valid_nx, rsp1_valid_nx;
    logic              rsp0_err_nx, rsp1_err_nx;
    logic [DATA_W-1:0] rsp0_rdata_nx, rsp1_rdata_nx;

    logic              any_c, sel_c, accept_c, sel_we_c, prot_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    // On contention the requester not granted last wins; otherwise the lone requester.
    assign any_c       = req0_valid | req1_valid;
    assign sel_c       = (req0_valid && req1_valid) ? favour : req1_valid;
    assign req0_ready  = rst_n && (state == IDLE) && any_c && !sel_c;
    assign req1_ready  = rst_n && (state == IDLE) && any_c &&  sel_c;
    assign accept_c    = req0_ready | req1_ready;
    assign sel_we_c    = sel_c ? req1_we    : req0_we;
    assign sel_addr_c  = sel_c ? req1_addr  : req0_addr;
    assign sel_wdata_c = sel_c ? req1_wdata : req0_wdata;

`ifdef MEM_WR_PROTECT_EN
    assign prot_c = sel_we_c && (sel_addr_c <= PROT_TOP);
`else
    assign prot_c = 1'b0;
    logic unused_prot;
    assign unused_prot = ^PROT_TOP;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            favour     <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            favour     <= favour_nx;
            lat_we     <= lat_we_nx;
            lat_err    <= lat_err_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            busy       <= busy_nx;
            grant_id   <= grant_nx;
            rsp0_valid <= rsp0_valid_nx;
            rsp1_valid <= rsp1_valid_nx;
            rsp0_err   <= rsp0_err_nx;
            rsp1_err   <= rsp1_err_nx;
            rsp0_rdata <= rsp0_rdata_nx;
            rsp1_rdata <= rsp1_rdata_nx;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        favour_nx     = favour;
        lat_we_nx     = lat_we;
        lat_err_nx    = lat_err;
        mem_we_nx     = 1'b0;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        busy_nx       = busy;
        grant_nx      = grant_id;
        rsp0_valid_nx = 1'b0;
        rsp1_valid_nx = 1'b0;
        rsp0_err_nx   = 1'b0;
        rsp1_err_nx   = 1'b0;
        rsp0_rdata_nx = rsp0_rdata;
        rsp1_rdata_nx = rsp1_rdata;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nx     = ACCESS;
                    mem_addr_nx  = sel_addr_c;
                    mem_wdata_nx = sel_wdata_c;
                    mem_we_nx    = sel_we_c && !prot_c;
                    lat_we_nx    = sel_we_c;
                    lat_err_nx   = prot_c;
                    grant_nx     = sel_c;
                    favour_nx    = !sel_c;
                    busy_nx      = 1'b1;
                end
            end
            ACCESS: begin
                cnt_nx = '0;
                if (lat_we) begin
                    state_nx      = RESP;
                    rsp0_valid_nx = !grant_id;
                    rsp1_valid_nx =  grant_id;
                    rsp0_err_nx   = lat_err && !grant_id;
                    rsp1_err_nx   = lat_err &&  grant_id;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(RD_LAT - 1)) begin
                    state_nx      = RESP;
                    rsp0_valid_nx = !grant_id;
                    rsp1_valid_nx =  grant_id;
                    if (grant_id) rsp1_rdata_nx = mem_rdata;
                    else          rsp0_rdata_nx = mem_rdata;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_4kb_arbiter.sv
// Directed self-checking bench for rom_4kb_arbiter with a 1-cycle-latency memory model (RD_LAT=1).
module tb_rom_4kb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [11:0] req0_addr;
    logic [7:0]  req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [11:0] req1_addr;
    logic [7:0]  req1_wdata;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [7:0]  rsp0_rdata, rsp1_rdata;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        busy, grant_id;

    int errors = 0;
    int checks = 0;
    int rsp0_pulses = 0;
    int rsp1_pulses = 0;
    int wr010_seen  = 0;

    logic [7:0]  mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    rom_4kb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Synchronous memory with one cycle read latency; pl_* lets the bench preload it.
    always @(posedge clk) begin
        if (pl_en)       mem[pl_addr]  <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (rsp0_valid) rsp0_pulses++;
        if (rsp1_valid) rsp1_pulses++;
        if (mem_we && mem_addr == 12'h010) wr010_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic we, input logic [11:0] a, input logic [7:0] d);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [11:0] a, input logic [7:0] d);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive0(1'b1, 1'b0, 12'h000, 8'h00);
        drive1(1'b0, 1'b0, 12'h000, 8'h00);
        step(); step(); #1;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
             rsp0_err, rsp1_err, busy, grant_id} !== 46'd0) begin
            errors++; $display("FAIL reset_outputs: got nonzero output, busy=%b mem_we=%b", busy, mem_we);
        end
        checks++;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        rst_n = 1'b1; #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL release_ready: got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL dropped_valid_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_read();
        drive0(1'b1, 1'b1, 12'h000, 8'hA5); #1;
        step();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, busy, grant_id} !== {1'b1, 12'h000, 8'hA5, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wr_access: got we=%b a=%h d=%h busy=%b g=%b", mem_we, mem_addr, mem_wdata, busy, grant_id);
        end
        drive0(1'b0, 1'b0, 12'h000, 8'h00);
        step();
        checks++;
        if ({mem_we, rsp0_valid, rsp0_err, rsp1_valid} !== 4'b0100) begin
            errors++; $display("FAIL wr_resp: got we,v0,e0,v1=%b want 0100", {mem_we, rsp0_valid, rsp0_err, rsp1_valid});
        end
        step();
        checks++;
        if ({rsp0_valid, busy} !== 2'b00) begin errors++; $display("FAIL wr_idle: got %b want 00", {rsp0_valid, busy}); end
        drive0(1'b1, 1'b0, 12'h000, 8'h00);
        step();
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_access_we: got %b want 0", mem_we); end
        drive0(1'b0, 1'b0, 12'h000, 8'h00);
        step();
        checks++;
        if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL rd_wait_valid: got %b want 0", rsp0_valid); end
        step();
        checks++;
        if ({rsp0_valid, rsp0_rdata, rsp1_valid} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++; $display("FAIL rd_resp: got v0=%b d=%h v1=%b want 1 a5 0", rsp0_valid, rsp0_rdata, rsp1_valid);
        end
        step();
        checks++;
        if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: got %b want 0", rsp0_valid); end
    endtask

    task automatic test_contention();
        int ng = 0;
        int r0, r1, overlap;
        logic [3:0] g;
        logic prev_busy;
        g = 4'b0000; prev_busy = 1'b0; overlap = 0;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        preload(12'h002, 8'hC3);
        r0 = rsp0_pulses; r1 = rsp1_pulses;
        drive0(1'b1, 1'b1, 12'h001, 8'h5A);
        drive1(1'b1, 1'b0, 12'h002, 8'h00);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL cont_first_ready: got %b want 10", {req0_ready, req1_ready});
        end
        for (int c = 0; c < 30; c++) begin
            step();
            if (busy && !prev_busy) begin
                if (ng < 4) g[3 - ng] = grant_id;
                ng++;
                if (ng == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            end
            prev_busy = busy;
            if (rsp0_valid && rsp1_valid) overlap++;
            if (rsp0_valid) begin
                checks++;
                if (grant_id !== 1'b0) begin errors++; $display("FAIL cont_rsp0_owner: got %b want 0", grant_id); end
            end
            if (rsp1_valid) begin
                checks++;
                if ({grant_id, rsp1_rdata} !== {1'b1, 8'hC3}) begin
                    errors++; $display("FAIL cont_rsp1: got g=%b d=%h want 1 c3", grant_id, rsp1_rdata);
                end
            end
        end
        checks++;
        if (ng !== 4) begin errors++; $display("FAIL cont_grant_count: got %0d want 4", ng); end
        checks++;
        if (g !== 4'b0101) begin errors++; $display("FAIL cont_grant_order: got %b want 0101", g); end
        checks++;
        if ({rsp0_pulses - r0, rsp1_pulses - r1} !== {32'd2, 32'd2}) begin
            errors++; $display("FAIL cont_rsp_counts: got %0d,%0d want 2,2", rsp0_pulses - r0, rsp1_pulses - r1);
        end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL cont_overlap: got %0d want 0", overlap); end
        checks++;
        if (mem[12'h001] !== 8'h5A) begin errors++; $display("FAIL cont_mem1: got %h want 5a", mem[12'h001]); end
    endtask

    task automatic test_boundary();
        int r0;
        r0 = rsp0_pulses;
        drive1(1'b1, 1'b1, 12'hFFF, 8'hFF);
        step();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, grant_id} !== {1'b1, 12'hFFF, 8'hFF, 1'b1}) begin
            errors++; $display("FAIL bnd_access: got we=%b a=%h d=%h g=%b", mem_we, mem_addr, mem_wdata, grant_id);
        end
        drive1(1'b0, 1'b0, 12'h000, 8'h00);
        drive0(1'b1, 1'b1, 12'h010, 8'h77); #1;
        checks++;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL bnd_busy_ready0: got %b want 0", req0_ready); end
        step();
        checks++;
        if ({rsp1_valid, req0_ready} !== 2'b10) begin
            errors++; $display("FAIL bnd_resp: got v1,rdy0=%b want 10", {rsp1_valid, req0_ready});
        end
        drive0(1'b0, 1'b0, 12'h000, 8'h00);
        step();
        checks++;
        if ({mem_addr, busy} !== {12'hFFF, 1'b0}) begin
            errors++; $display("FAIL bnd_addr_hold: got a=%h busy=%b want fff 0", mem_addr, busy);
        end
        drive1(1'b1, 1'b0, 12'hFFF, 8'h00);
        step();
        drive1(1'b0, 1'b0, 12'h000, 8'h00);
        step(); step();
        checks++;
        if ({rsp1_valid, rsp1_rdata} !== {1'b1, 8'hFF}) begin
            errors++; $display("FAIL bnd_readback: got v1=%b d=%h want 1 ff", rsp1_valid, rsp1_rdata);
        end
        step();
        checks++;
        if ({rsp0_pulses - r0, wr010_seen} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL bnd_dropped_req0: got rsp0=%0d wr=%0d want 0 0", rsp0_pulses - r0, wr010_seen);
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        drive0(1'b1, 1'b0, 12'h000, 8'h00);
        step();
        drive0(1'b0, 1'b0, 12'h000, 8'h00);
        step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_wait_busy: got %b want 1", busy); end
        r0 = rsp0_pulses;
        rst_n = 1'b0; #1;
        checks++;
        if ({busy, mem_we, rsp0_valid, rsp1_valid} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_now: got %b want 0000", {busy, mem_we, rsp0_valid, rsp1_valid});
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if (rsp0_pulses - r0 !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d want 0", rsp0_pulses - r0); end
        drive0(1'b1, 1'b0, 12'h000, 8'h00);
        step();
        drive0(1'b0, 1'b0, 12'h000, 8'h00);
        step(); step();
        checks++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL mid_after_read: got v0=%b d=%h want 1 a5", rsp0_valid, rsp0_rdata);
        end
        step();
    endtask

    task automatic test_protect();
        preload(12'h0FF, 8'h42);
        drive0(1'b1, 1'b1, 12'h0FF, 8'h00);
        step();
`ifdef MEM_WR_PROTECT_EN
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL prot_we_low: got %b want 0", mem_we); end
`else
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL noprot_we_high: got %b want 1", mem_we); end
`endif
        drive0(1'b0, 1'b0, 12'h000, 8'h00);
        step();
`ifdef MEM_WR_PROTECT_EN
        checks++;
        if ({rsp0_valid, rsp0_err} !== 2'b11) begin errors++; $display("FAIL prot_err: got %b want 11", {rsp0_valid, rsp0_err}); end
`else
        checks++;
        if ({rsp0_valid, rsp0_err} !== 2'b10) begin errors++; $display("FAIL noprot_err: got %b want 10", {rsp0_valid, rsp0_err}); end
`endif
        step();
        drive0(1'b1, 1'b0, 12'h0FF, 8'h00);
        step();
        drive0(1'b0, 1'b0, 12'h000, 8'h00);
        step(); step();
`ifdef MEM_WR_PROTECT_EN
        checks++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b1, 8'h42}) begin
            errors++; $display("FAIL prot_readback: got v0=%b d=%h want 1 42", rsp0_valid, rsp0_rdata);
        end
`else
        checks++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL noprot_readback: got v0=%b d=%h want 1 00", rsp0_valid, rsp0_rdata);
        end
`endif
        step();
        drive0(1'b1, 1'b1, 12'h100, 8'h3C);
        step();
        checks++;
        if ({mem_we, mem_addr} !== {1'b1, 12'h100}) begin
            errors++; $display("FAIL prot_100_we: got we=%b a=%h want 1 100", mem_we, mem_addr);
        end
        drive0(1'b0, 1'b0, 12'h000, 8'h00);
        step();
        checks++;
        if ({rsp0_valid, rsp0_err} !== 2'b10) begin errors++; $display("FAIL prot_100_err: got %b want 10", {rsp0_valid, rsp0_err}); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_boundary();
        test_reset_mid();
        test_protect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
